i2c_bit_engine: RTL and testbench
=================================

Name: i2c_bit_engine

Overview:
- Bit/byte-level I2C master engine, directly downstream of the I2C master control FSM.
- Turns one command (START, STOP, WRITE byte, READ byte) into open-drain SCL/SDA waveforms.
- Returns the slave ACK for writes and the received byte for reads.
- Single master; no arbitration and no clock stretching.

Parameters:
- DIV, 125: clk cycles per quarter SCL period. 100 kHz at 50 MHz. Legal range is DIV >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle, can accept a command
- cmd  in  2  00=START, 01=STOP, 10=WRITE, 11=READ
- wr_data  in  8  byte for WRITE, sent MSB first
- rd_nack  in  1  master ACK bit for READ: 0=ACK, 1=NACK
- done  out  1  one-cycle pulse when a command completes
- rd_data  out  8  byte received by the last READ
- ack_rcvd  out  1  WRITE: sampled slave ACK (0=ACK). READ: copy of the bit sent
- busy  out  1  command in progress
- scl_oe  out  1  1 pulls SCL low; 0 releases it
- sda_oe  out  1  1 pulls SDA low; 0 releases it
- sda_in  in  1  synchronised SDA line level

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: scl_oe=0, sda_oe=0, done=0, rd_data=0, ack_rcvd=0, busy=0, cmd_ready=1, state=IDLE.
- Reset mid-command releases both lines immediately. Recovery (STOP) is the upstream FSM's responsibility.
- Handshake:
  - Accept when cmd_valid && cmd_ready. Latch cmd, wr_data and rd_nack.
  - cmd_ready = (state==IDLE). busy = !cmd_ready.
  - The acceptance cycle is offset 0.
- States: IDLE, START, STOP, DATA.
  - Quarter counter qcnt counts 0..DIV-1. Phase counter ph counts 0..3. Bit counter bcnt counts 0..8 in DATA.
  - Phase p of bit b occupies offsets 1+(4b+p)*DIV through (4b+p+1)*DIV.
- START (N=1 bit):
  - ph0/ph1: sda_oe=0, scl_oe=0.
  - ph2: sda_oe=1, scl_oe=0. This is the start condition.
  - ph3: sda_oe=1, scl_oe=1.
  - Valid from idle and as a repeated start after a byte.
- STOP (N=1 bit):
  - ph0: sda_oe=1, scl_oe=1.
  - ph1/ph2: sda_oe=1, scl_oe=0.
  - ph3: sda_oe=0, scl_oe=0.
- DATA (N=9 bits):
  - Every bit: ph0 and ph3 scl_oe=1; ph1 and ph2 scl_oe=0.
  - sda_oe is set at the start of ph0 and held through ph3.
  - WRITE: bits 0..7 drive sda_oe = ~wr_data[7-b]. Bit 8 drives sda_oe=0.
  - WRITE: sda_in is sampled into ack_rcvd on the last cycle of bit 8 ph1, at offset (4*8+2)*DIV.
  - READ: bits 0..7 drive sda_oe=0. sda_in is shifted into a shift register, MSB first, on the last cycle of ph1.
  - READ: bit 8 drives sda_oe = ~rd_nack, and ack_rcvd <= rd_nack.
  - READ: rd_data updates at done and holds until the next READ completes.
- Completion:
  - done=1 at offset 4*DIV*N+1, i.e. 4*DIV+1 for START/STOP and 36*DIV+1 for WRITE/READ.
  - State returns to IDLE in that same cycle, so cmd_ready=1 and a back-to-back accept is allowed.
- Idle hold: in IDLE, scl_oe and sda_oe keep their last values. After a byte or START, SCL stays low. After STOP, both lines are released.
- cmd_valid while busy is ignored (not accepted) and has no effect.
- Counters wrap only at their defined limits. No command is aborted except by reset.

Test Plan:
- Reset asserted mid-WRITE at offset 50 (DIV=4) -> scl_oe=0, sda_oe=0, busy=0, cmd_ready=1 asynchronously. A following START completes normally with done at offset 17.
- START from idle, DIV=4 -> sda_oe rises at offset 9 while scl_oe=0; scl_oe rises at offset 13; done pulses at offset 17 for exactly 1 cycle.
- WRITE 0xA5, slave model pulls SDA low in bit 8:
  - sda_oe during SCL-high of bits 0..7 is 0,1,0,1,1,0,1,0.
  - ack_rcvd=0 and done at offset 145.
- WRITE 0x00, no slave (sda_in=1 throughout) -> sda_oe=1 for bits 0..7, ack_rcvd=1 at done.
- READ, slave drives 0x3C, rd_nack=1 -> rd_data=0x3C at done (offset 145), sda_oe=0 in bit 8, ack_rcvd=1.
- Then READ with rd_nack=0 -> sda_oe=1 in bit 8.
- Back-to-back START, WRITE 0x50, STOP with cmd_valid held high:
  - Each command is accepted in the same cycle as the previous done.
  - The STOP ends with scl_oe=0 and sda_oe=0.
  - SDA rises while SCL is released.

Source files
------------

// File: rtl/i2c_bit_engine.sv
// Bit/byte-level I2C master engine: turns START/STOP/WRITE/READ commands into
// open-drain SCL/SDA waveforms, one quarter-SCL phase per DIV clocks.
module i2c_bit_engine #(
    parameter int DIV = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] wr_data,
    input  logic       rd_nack,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       ack_rcvd,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);

    localparam int QW = $clog2(DIV);
    localparam logic [QW-1:0] QLAST = QW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, STOP, DATA} state_t;

    state_t        state, state_n;
    logic [QW-1:0] qcnt, qcnt_n;
    logic [1:0]    ph, ph_n;
    logic [3:0]    bcnt, bcnt_n;
    logic          scl_n, sda_n, done_n;
    logic          accept;
    logic          rd_q, nack_q;
    logic [7:0]    wr_q, shreg;
    logic          src_rd, src_nack;
    logic [7:0]    src_wd;

    // Line drive {scl_oe, sda_oe} for a given phase of a given bit.
    function automatic logic [1:0] drive(state_t st, logic [1:0] p, logic [3:0] b,
                                         logic rd, logic [7:0] wd, logic nk);
        logic [1:0] r;
        logic [2:0] idx;
        r   = 2'b00;
        idx = 3'(4'd7 - b);
        case (st)
            START:   r = {p == 2'd3, p[1]};
            STOP:    r = {p == 2'd0, p != 2'd3};
            DATA:    r = {(p == 2'd0) || (p == 2'd3),
                          (b == 4'd8) ? (rd & ~nk) : (~rd & ~wd[idx])};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    assign accept    = (state == IDLE) && cmd_valid;
    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;
    // The first phase is driven from the incoming command, later ones from the latched copy.
    assign src_rd    = accept ? cmd[0]  : rd_q;
    assign src_wd    = accept ? wr_data : wr_q;
    assign src_nack  = accept ? rd_nack : nack_q;

    always_comb begin
        state_n = state;
        qcnt_n  = qcnt;
        ph_n    = ph;
        bcnt_n  = bcnt;
        done_n  = 1'b0;
        scl_n   = scl_oe;
        sda_n   = sda_oe;
        if (state == IDLE) begin
            if (cmd_valid) begin
                case (cmd)
                    2'b00:   state_n = START;
                    2'b01:   state_n = STOP;
                    default: state_n = DATA;
                endcase
                qcnt_n = '0;
                ph_n   = 2'd0;
                bcnt_n = 4'd0;
                {scl_n, sda_n} = drive(state_n, 2'd0, 4'd0, src_rd, src_wd, src_nack);
            end
        end else if (qcnt == QLAST) begin
            qcnt_n = '0;
            ph_n   = ph + 2'd1;
            if (ph == 2'd3 && (state != DATA || bcnt == 4'd8)) begin
                state_n = IDLE;
                done_n  = 1'b1;
                bcnt_n  = 4'd0;
            end else begin
                if (ph == 2'd3) begin
                    bcnt_n = bcnt + 4'd1;
                end
                {scl_n, sda_n} = drive(state, ph_n, bcnt_n, src_rd, src_wd, src_nack);
            end
        end else begin
            qcnt_n = qcnt + QW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            qcnt   <= '0;
            ph     <= 2'd0;
            bcnt   <= 4'd0;
            scl_oe <= 1'b0;
            sda_oe <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            qcnt   <= qcnt_n;
            ph     <= ph_n;
            bcnt   <= bcnt_n;
            scl_oe <= scl_n;
            sda_oe <= sda_n;
            done   <= done_n;
        end
    end

    // SDA is sampled on the last clock of the SCL-high first half (phase 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q     <= 1'b0;
            wr_q     <= 8'h00;
            nack_q   <= 1'b0;
            shreg    <= 8'h00;
            rd_data  <= 8'h00;
            ack_rcvd <= 1'b0;
        end else begin
            if (accept) begin
                rd_q   <= cmd[0];
                wr_q   <= wr_data;
                nack_q <= rd_nack;
            end
            if (state == DATA && ph == 2'd1 && qcnt == QLAST) begin
                if (bcnt == 4'd8) begin
                    if (!rd_q) begin
                        ack_rcvd <= sda_in;
                    end
                end else if (rd_q) begin
                    shreg <= {shreg[6:0], sda_in};
                end
            end
            if (done_n && state == DATA && rd_q) begin
                rd_data  <= shreg;
                ack_rcvd <= nack_q;
            end
        end
    end

endmodule

// File: tb/tb_i2c_bit_engine.sv
// Self-checking bench for i2c_bit_engine: offset-based line model, simple
// slave, per-cycle compare plus directed literal checks.
module tb_i2c_bit_engine;

    localparam int DIV   = 4;
    localparam int LIMIT = 400;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd       = 2'b00;
    logic [7:0] wr_data   = 8'h00;
    logic       rd_nack   = 1'b0;
    logic       cmd_ready, done, ack_rcvd, busy, scl_oe, sda_oe, sda_in;
    logic [7:0] rd_data;

    logic       slave_ack  = 1'b0;
    logic [7:0] slave_byte = 8'h00;
    logic       slave_pull = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic       m_busy = 1'b0, m_done = 1'b0, m_scl = 1'b0, m_sda = 1'b0;
    logic       m_ack = 1'b0, m_nk = 1'b0, m_sack = 1'b0;
    int         m_off = 0;
    logic [1:0] m_cmd = 2'b00;
    logic [7:0] m_wd = 8'h00, m_sb = 8'h00, m_rd = 8'h00;

    logic tr_scl [0:LIMIT];
    logic tr_sda [0:LIMIT];

    int         k;
    logic [7:0] pat;

    always #5 clk = ~clk;

    assign sda_in = !sda_oe && !slave_pull;

    i2c_bit_engine #(.DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .wr_data(wr_data), .rd_nack(rd_nack), .done(done),
        .rd_data(rd_data), .ack_rcvd(ack_rcvd), .busy(busy),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in)
    );

    function automatic int cmdLen(logic [1:0] c);
        return c[1] ? 36 * DIV : 4 * DIV;
    endfunction

    // Expected {scl_oe, sda_oe} at a given offset after acceptance.
    function automatic logic [1:0] busLines(logic [1:0] c, int off, logic [7:0] wd, logic nk);
        int q, b, p;
        logic scl, sda;
        q = (off - 1) / DIV;
        b = q / 4;
        p = q % 4;
        case (c)
            2'b00: begin scl = (p == 3); sda = (p >= 2); end
            2'b01: begin scl = (p == 0); sda = (p != 3); end
            default: begin
                scl = (p == 0) || (p == 3);
                if (b == 8) sda = (c == 2'b11) ? !nk : 1'b0;
                else        sda = (c == 2'b10) ? !wd[7-b] : 1'b0;
            end
        endcase
        return {scl, sda};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 1'b0; m_done = 1'b0; m_off = 0;
                m_scl = 1'b0; m_sda = 1'b0; m_rd = 8'h00; m_ack = 1'b0;
            end else begin
                m_done = 1'b0;
                if (m_busy) begin
                    m_off++;
                    if (m_off == cmdLen(m_cmd) + 1) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        if (m_cmd == 2'b11) begin
                            m_rd  = m_sb;
                            m_ack = m_nk;
                        end else if (m_cmd == 2'b10) begin
                            m_ack = !m_sack;
                        end
                    end else begin
                        {m_scl, m_sda} = busLines(m_cmd, m_off, m_wd, m_nk);
                    end
                end else if (cmd_valid) begin
                    m_busy = 1'b1; m_off = 1;
                    m_cmd = cmd; m_wd = wr_data; m_nk = rd_nack;
                    m_sb = slave_byte; m_sack = slave_ack;
                    {m_scl, m_sda} = busLines(m_cmd, m_off, m_wd, m_nk);
                end
            end
        end
    end

    // Slave: drives read data bits and, if enabled, the write ACK in bit 8.
    initial begin
        int b;
        forever begin
            @(negedge clk);
            slave_pull = 1'b0;
            if (m_busy && m_cmd[1]) begin
                b = (m_off - 1) / (4 * DIV);
                if (m_cmd[0]) slave_pull = (b < 8) ? !m_sb[7-b] : 1'b0;
                else          slave_pull = (b == 8) && m_sack;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checkOutput("scl_oe", scl_oe, m_scl);
            checkOutput("sda_oe", sda_oe, m_sda);
            checkOutput("done", done, m_done);
            checkOutput("busy", busy, m_busy);
            checkOutput("cmd_ready", cmd_ready, !m_busy);
            checkOutput("rd_data", rd_data, m_rd);
            if (!m_busy) checkOutput("ack_rcvd", ack_rcvd, m_ack);
        end
    end

    task automatic waitDone(input bit drop, output int k_done);
        k_done = -1;
        for (int i = 1; i <= LIMIT; i++) begin
            @(negedge clk);
            if (i == 1 && drop) cmd_valid = 1'b0;
            tr_scl[i] = scl_oe;
            tr_sda[i] = sda_oe;
            if (done) begin
                k_done = i;
                break;
            end
        end
        if (k_done < 0) checkOutput("done timeout", done, 1);
    endtask

    task automatic applyStimulus(input logic [1:0] c, input logic [7:0] wd, input logic nk,
                                 output int k_done);
        @(negedge clk);
        cmd = c; wr_data = wd; rd_nack = nk; cmd_valid = 1'b1;
        waitDone(1'b1, k_done);
    endtask

    task automatic sdaDuringSclHigh(output logic [7:0] p);
        for (int b = 0; b < 8; b++) p[7-b] = tr_sda[1 + (4*b + 1)*DIV + 1];
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset scl_oe", scl_oe, 0);
        checkOutput("reset sda_oe", sda_oe, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset cmd_ready", cmd_ready, 1);
        checkOutput("reset done", done, 0);
        checkOutput("reset rd_data", rd_data, 0);
        checkOutput("reset ack_rcvd", ack_rcvd, 0);
        @(negedge clk) rst_n = 1'b1;

        applyStimulus(2'b00, 8'h00, 1'b0, k);
        checkOutput("start done offset", k, 17);
        checkOutput("start sda before 9", tr_sda[8], 0);
        checkOutput("start sda at 9", tr_sda[9], 1);
        checkOutput("start scl at 9", tr_scl[9], 0);
        checkOutput("start scl at 12", tr_scl[12], 0);
        checkOutput("start scl at 13", tr_scl[13], 1);
        @(negedge clk);
        checkOutput("start done width", done, 0);

        slave_ack = 1'b1;
        applyStimulus(2'b10, 8'hA5, 1'b0, k);
        checkOutput("write A5 done offset", k, 145);
        checkOutput("write A5 ack", ack_rcvd, 0);
        sdaDuringSclHigh(pat);
        checkOutput("write A5 sda pattern", pat, 8'h5A);

        slave_ack = 1'b0;
        applyStimulus(2'b10, 8'h00, 1'b0, k);
        checkOutput("write 00 done offset", k, 145);
        checkOutput("write 00 nack", ack_rcvd, 1);
        sdaDuringSclHigh(pat);
        checkOutput("write 00 sda pattern", pat, 8'hFF);

        slave_byte = 8'h3C;
        applyStimulus(2'b11, 8'h00, 1'b1, k);
        checkOutput("read 3C done offset", k, 145);
        checkOutput("read 3C rd_data", rd_data, 8'h3C);
        checkOutput("read 3C ack_rcvd", ack_rcvd, 1);
        checkOutput("read nack sda bit8", tr_sda[1 + 33*DIV + 1], 0);

        slave_byte = 8'h81;
        applyStimulus(2'b11, 8'h00, 1'b0, k);
        checkOutput("read 81 rd_data", rd_data, 8'h81);
        checkOutput("read 81 ack_rcvd", ack_rcvd, 0);
        checkOutput("read ack sda bit8", tr_sda[1 + 33*DIV + 1], 1);

        @(negedge clk);
        cmd = 2'b00; cmd_valid = 1'b1;
        waitDone(1'b0, k);
        checkOutput("b2b start done offset", k, 17);
        cmd = 2'b10; wr_data = 8'h50; slave_ack = 1'b1;
        waitDone(1'b0, k);
        checkOutput("b2b write done offset", k, 145);
        checkOutput("b2b write ack", ack_rcvd, 0);
        cmd = 2'b01;
        waitDone(1'b1, k);
        checkOutput("b2b stop done offset", k, 17);
        checkOutput("stop scl ph0", tr_scl[4], 1);
        checkOutput("stop scl released ph2", tr_scl[12], 0);
        checkOutput("stop sda low ph2", tr_sda[12], 1);
        checkOutput("stop sda released ph3", tr_sda[13], 0);
        checkOutput("stop scl ph3", tr_scl[13], 0);
        checkOutput("stop final scl_oe", scl_oe, 0);
        checkOutput("stop final sda_oe", sda_oe, 0);

        @(negedge clk);
        cmd = 2'b10; wr_data = 8'h00; slave_ack = 1'b0; cmd_valid = 1'b1;
        @(negedge clk) cmd_valid = 1'b0;
        repeat (49) @(negedge clk);
        checkOutput("pre-reset scl_oe", scl_oe, 1);
        checkOutput("pre-reset sda_oe", sda_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset scl_oe", scl_oe, 0);
        checkOutput("async reset sda_oe", sda_oe, 0);
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset cmd_ready", cmd_ready, 1);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        applyStimulus(2'b00, 8'h00, 1'b0, k);
        checkOutput("post-reset start done offset", k, 17);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
